// File: rtl/ecc_bus_pkg.sv
// Shared types and SECDED(39,32) code construction for the responder-side bus ECC.
// Codeword layout: {parity[6:0], data[31:0]}; the all-zero word is a valid codeword.
package ecc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RESP  = 2'd2
    } ecc_dec_state_e;

    localparam int DataWidth = 32;
    localparam int ErrCorr   = 0;
    localparam int ErrUncorr = 1;
    localparam logic [38:0] ZeroCodeword = 39'h0;

    // Column of data bit idx in the check matrix: the idx-th weight-3 7-bit value in
    // ascending order. Odd-weight distinct columns give single-correct/double-detect.
    function automatic logic [6:0] secded_col(input int idx);
        logic [6:0] col;
        logic [6:0] cand;
        int found;
        int ones;
        col   = '0;
        found = 0;
        for (int v = 0; v < 128; v++) begin
            cand = v[6:0];
            ones = 0;
            for (int b = 0; b < 7; b++) begin
                ones += int'(cand[b]);
            end
            if (ones == 3) begin
                if (found == idx) begin
                    col = cand;
                end
                found++;
            end
        end
        return col;
    endfunction

    // Data bits that feed parity bit row.
    function automatic logic [31:0] secded_row(input int row);
        logic [31:0] mask;
        logic [6:0]  col;
        mask = '0;
        for (int j = 0; j < 32; j++) begin
            col     = secded_col(j);
            mask[j] = col[row];
        end
        return mask;
    endfunction

endpackage

// File: rtl/xbar_demux_bus_if.sv
// XBAR_DEMUX_BUS request/response bus; DATA_WIDTH sets wdata and r_rdata width.
interface XBAR_DEMUX_BUS #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] add;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_valid;
    logic                  r_gnt;
    logic                  barrier;
    logic                  exec_cancel;
    logic                  exec_stall;
    logic                  busy;

    modport Master (
        output req, add, we, be, wdata, r_gnt, barrier, exec_cancel, exec_stall,
        input  gnt, r_rdata, r_valid, busy
    );

    modport Slave (
        input  req, add, we, be, wdata, r_gnt, barrier, exec_cancel, exec_stall,
        output gnt, r_rdata, r_valid, busy
    );
endinterface

// File: rtl/prim_secded_39_32_dec.sv
// SECDED(39,32) decoder: syndrome, single-bit data correction, err_o = {double, single}.
module prim_secded_39_32_dec
    import ecc_bus_pkg::*;
(
    input  logic [38:0] data_i,
    output logic [31:0] data_o,
    output logic [6:0]  syndrome_o,
    output logic [1:0]  err_o
);
    for (genvar gi = 0; gi < 7; gi++) begin : g_syndrome
        localparam logic [31:0] RowMask = secded_row(gi);
        assign syndrome_o[gi] = (^(data_i[31:0] & RowMask)) ^ data_i[32 + gi];
    end

    // A parity-bit error yields a weight-1 syndrome, which matches no data column.
    for (genvar gi = 0; gi < 32; gi++) begin : g_correct
        localparam logic [6:0] Col = secded_col(gi);
        assign data_o[gi] = data_i[gi] ^ (syndrome_o == Col);
    end

    assign err_o[ErrCorr]   = ^syndrome_o;
    assign err_o[ErrUncorr] = (|syndrome_o) & ~(^syndrome_o);
endmodule

// File: rtl/prim_secded_39_32_enc.sv
// SECDED(39,32) encoder: appends 7 parity bits above the data.
module prim_secded_39_32_enc
    import ecc_bus_pkg::*;
(
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);
    logic [6:0] parity;

    for (genvar gi = 0; gi < 7; gi++) begin : g_parity
        localparam logic [31:0] RowMask = secded_row(gi);
        assign parity[gi] = ^(data_i & RowMask);
    end

    assign data_o = {parity, data_i};
endmodule

// File: rtl/xbar_demux_bus_ecc_err_cnt.sv
// Saturating event counter; clear beats a same-cycle increment.
module xbar_demux_bus_ecc_err_cnt #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);
    logic [Width-1:0] cnt_reg;
    logic [Width-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear_i) begin
            cnt_next = '0;
        end else if (inc_i && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_o = cnt_reg;
endmodule

// File: rtl/xbar_demux_bus_ecc_dec.sv
// Responder-side ECC: corrects 39b write data to a 32b target, encodes read data back,
// and drops uncorrectable writes with a local zero response once the target is drained.
module xbar_demux_bus_ecc_dec
    import ecc_bus_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    parameter int CntWidth       = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    XBAR_DEMUX_BUS.Slave        bus_in,
    XBAR_DEMUX_BUS.Master       bus_out,
    input  logic                clear_i,
    output logic [6:0]          syndrome_o,
    output logic [1:0]          err_o,
    output logic [CntWidth-1:0] corr_cnt_o,
    output logic [CntWidth-1:0] uncorr_cnt_o,
    output logic                wr_drop_o
);
    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam logic [OutW-1:0] OutMax = OutW'(MaxOutstanding);

    ecc_dec_state_e       state_reg, state_next;
    logic [OutW-1:0]      outst_reg, outst_next;
    logic [6:0]           syndrome_reg;
    logic [1:0]           err_reg;
    logic                 wr_drop_reg;

    logic [DataWidth-1:0] dec_data;
    logic [6:0]           dec_syndrome;
    logic [1:0]           dec_err;
    logic [38:0]          enc_rdata;

    logic out_full, uncorr_req, req_fwd, in_gnt;
    logic wr_accept, corr_evt, uncorr_evt, syn_evt;
    logic out_issue, out_retire;

    prim_secded_39_32_dec u_dec (
        .data_i     (bus_in.wdata),
        .data_o     (dec_data),
        .syndrome_o (dec_syndrome),
        .err_o      (dec_err)
    );

    prim_secded_39_32_enc u_enc (
        .data_i (bus_out.r_rdata),
        .data_o (enc_rdata)
    );

    assign out_full   = (outst_reg == OutMax);
    assign uncorr_req = bus_in.req & bus_in.we & dec_err[ErrUncorr];

    // A bad write is never forwarded; it is granted locally only with nothing in flight,
    // so its local response cannot overtake a target response.
    always_comb begin
        state_next = state_reg;
        req_fwd    = 1'b0;
        in_gnt     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (uncorr_req) begin
                    if (outst_reg == '0) begin
                        in_gnt     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = DRAIN;
                    end
                end else begin
                    req_fwd = bus_in.req & ~out_full;
                    in_gnt  = req_fwd & bus_out.gnt;
                end
            end
            DRAIN: begin
                if (!uncorr_req) begin
                    state_next = IDLE;
                end else if (outst_reg == '0) begin
                    in_gnt     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus_in.r_gnt) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_issue  = req_fwd & bus_out.gnt;
    assign out_retire = bus_out.r_valid & bus_out.r_gnt;

    always_comb begin
        outst_next = outst_reg;
        case ({out_issue, out_retire})
            2'b10:   outst_next = outst_reg + OutW'(1);
            2'b01:   outst_next = outst_reg - OutW'(1);
            default: outst_next = outst_reg;
        endcase
    end

    assign wr_accept  = bus_in.req & in_gnt & bus_in.we;
    assign corr_evt   = wr_accept & dec_err[ErrCorr];
    assign uncorr_evt = wr_accept & dec_err[ErrUncorr];
    assign syn_evt    = wr_accept & (|dec_syndrome);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            outst_reg    <= '0;
            syndrome_reg <= '0;
            err_reg      <= '0;
            wr_drop_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            outst_reg   <= outst_next;
            wr_drop_reg <= uncorr_evt;
            if (clear_i) begin
                syndrome_reg <= '0;
                err_reg      <= '0;
            end else begin
                if (syn_evt) begin
                    syndrome_reg <= dec_syndrome;
                end
                err_reg <= err_reg | {uncorr_evt, corr_evt};
            end
        end
    end

    xbar_demux_bus_ecc_err_cnt #(.Width(CntWidth)) u_corr_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .inc_i   (corr_evt),
        .cnt_o   (corr_cnt_o)
    );

    xbar_demux_bus_ecc_err_cnt #(.Width(CntWidth)) u_uncorr_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .inc_i   (uncorr_evt),
        .cnt_o   (uncorr_cnt_o)
    );

    assign bus_out.req         = req_fwd;
    assign bus_out.add         = bus_in.add;
    assign bus_out.we          = bus_in.we;
    assign bus_out.be          = bus_in.be;
    assign bus_out.wdata       = dec_data;
    assign bus_out.barrier     = bus_in.barrier;
    assign bus_out.exec_cancel = bus_in.exec_cancel;
    assign bus_out.exec_stall  = bus_in.exec_stall;
    assign bus_out.r_gnt       = bus_in.r_gnt & (state_reg != RESP);

    assign bus_in.gnt     = in_gnt;
    assign bus_in.busy    = bus_out.busy;
    assign bus_in.r_valid = (state_reg == RESP) ? 1'b1 : bus_out.r_valid;
    assign bus_in.r_rdata = (state_reg == RESP) ? ZeroCodeword : enc_rdata;

    assign syndrome_o = syndrome_reg;
    assign err_o      = err_reg;
    assign wr_drop_o  = wr_drop_reg;
endmodule

// File: tb/tb_xbar_demux_bus_ecc_dec.sv
// Directed bench for xbar_demux_bus_ecc_dec with queue scoreboards for write data and responses.
module tb_xbar_demux_bus_ecc_dec;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    XBAR_DEMUX_BUS #(.DATA_WIDTH(39)) bin ();
    XBAR_DEMUX_BUS #(.DATA_WIDTH(32)) bout ();

    logic       clear;
    logic [6:0] syndrome;
    logic [1:0] err;
    logic [1:0] corr_cnt;
    logic [1:0] uncorr_cnt;
    logic       wr_drop;

    int checks   = 0;
    int failures = 0;
    logic [38:0] rq[$];
    logic [31:0] wq[$];
    logic [6:0]  col[32];

    xbar_demux_bus_ecc_dec #(.MaxOutstanding(4), .CntWidth(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus_in       (bin),
        .bus_out      (bout),
        .clear_i      (clear),
        .syndrome_o   (syndrome),
        .err_o        (err),
        .corr_cnt_o   (corr_cnt),
        .uncorr_cnt_o (uncorr_cnt),
        .wr_drop_o    (wr_drop)
    );

    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [6:0] p;
        p = '0;
        for (int j = 0; j < 32; j++) if (d[j]) p ^= col[j];
        return {p, d};
    endfunction

    function automatic logic [6:0] syn_of(input int b);
        logic [6:0] s;
        s = '0;
        if (b < 32) s = col[b];
        else s[b-32] = 1'b1;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bin.req     = 1'b0;
        bin.we      = 1'b0;
        bout.r_valid = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [38:0] cw);
        bin.req   = 1'b1;
        bin.we    = we;
        bin.add   = addr;
        bin.wdata = cw;
    endtask

    task automatic resp(input logic [31:0] d);
        step();
        bout.r_valid = 1'b1;
        bout.r_rdata = d;
        rq.push_back(enc(d));
        #1;
        chk("rsp_valid", bin.r_valid, 1);
        chk("rsp_rdata", bin.r_rdata, rq.pop_front());
    endtask

    task automatic wr_fwd(input logic [31:0] d, input logic [38:0] flip, input logic clr);
        step();
        drive(1'b1, 32'h100, enc(d) ^ flip);
        clear = clr;
        wq.push_back(d);
        #1;
        chk("wr_out_req", bout.req, 1);
        chk("wr_in_gnt", bin.gnt, 1);
        chk("wr_out_wdata", bout.wdata, wq.pop_front());
        resp(~d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [6:0] c;
        int fb[4];
        int corr_exp;
        logic [38:0] zcw;

        n = 0;
        for (int v = 1; v < 128; v++) begin
            c = 7'(v);
            if ($countones(c) == 3 && n < 32) begin
                col[n] = c;
                n++;
            end
        end
        fb  = '{0, 31, 34, 38};
        zcw = '0;

        rst = 1'b1;
        clear = 1'b0;
        bin.req = 0; bin.we = 0; bin.add = '0; bin.be = 4'hF; bin.wdata = '0;
        bin.r_gnt = 1; bin.barrier = 0; bin.exec_cancel = 0; bin.exec_stall = 0;
        bout.gnt = 1; bout.r_valid = 0; bout.r_rdata = '0; bout.busy = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_syndrome", syndrome, 0);
        chk("rst_err", err, 0);
        chk("rst_corr", corr_cnt, 0);
        chk("rst_uncorr", uncorr_cnt, 0);
        chk("rst_drop", wr_drop, 0);
        chk("rst_rvalid", bin.r_valid, 0);
        rst = 1'b0;

        bout.busy = 1'b1; bin.barrier = 1'b1;
        #1;
        chk("pass_busy", bin.busy, 1);
        chk("pass_barrier", bout.barrier, 1);
        bout.busy = 1'b0; bin.barrier = 1'b0;

        // Clean write
        wr_fwd(32'hDEADBEEF, '0, 1'b0);
        chk("t1_corr", corr_cnt, 0);
        chk("t1_err", err, 0);
        chk("t1_syn", syndrome, 0);

        // Single-bit error on data bit 5
        wr_fwd(32'h12345678, 39'h1 << 5, 1'b0);
        chk("t2_corr", corr_cnt, 1);
        chk("t2_err", err, 2'b01);
        chk("t2_syn", syndrome, syn_of(5));
        wr_fwd(32'hCAFEF00D, '0, 1'b0);
        chk("t2_syn_stable", syndrome, syn_of(5));
        chk("t2_corr_stable", corr_cnt, 1);

        // Double-bit error with nothing outstanding: dropped, local response
        step();
        drive(1'b1, 32'h104, enc(32'h0F0F0F0F) ^ ((39'h1 << 3) | (39'h1 << 17)));
        bin.r_gnt = 1'b0;
        #1;
        chk("t3_out_req", bout.req, 0);
        chk("t3_in_gnt", bin.gnt, 1);
        rq.push_back(zcw);
        step();
        #1;
        chk("t3_drop", wr_drop, 1);
        chk("t3_rvalid", bin.r_valid, 1);
        chk("t3_rdata", bin.r_rdata, rq[0]);
        chk("t3_uncorr", uncorr_cnt, 1);
        chk("t3_err", err, 2'b11);
        chk("t3_syn", syndrome, syn_of(3) ^ syn_of(17));
        step();
        #1;
        chk("t3_rvalid_held", bin.r_valid, 1);
        chk("t3_drop_pulse", wr_drop, 0);
        bin.r_gnt = 1'b1;
        #1;
        chk("t3_rdata_acc", bin.r_rdata, rq.pop_front());
        step();
        #1;
        chk("t3_rvalid_done", bin.r_valid, 0);

        // Two reads in flight (with garbage wdata), then a double-error write drains first
        step();
        drive(1'b0, 32'h200, enc(32'h1) ^ 39'h3);
        #1;
        chk("t4_rd0_gnt", bin.gnt, 1);
        chk("t4_rd0_req", bout.req, 1);
        step();
        drive(1'b0, 32'h204, enc(32'h1) ^ 39'h3);
        #1;
        chk("t4_rd1_gnt", bin.gnt, 1);
        step();
        drive(1'b1, 32'h208, enc(32'h55AA55AA) ^ ((39'h1 << 8) | (39'h1 << 30)));
        #1;
        chk("t4_bad_gnt", bin.gnt, 0);
        chk("t4_bad_req", bout.req, 0);
        step();
        drive(1'b1, 32'h208, enc(32'h55AA55AA) ^ ((39'h1 << 8) | (39'h1 << 30)));
        #1;
        chk("t4_drain_gnt", bin.gnt, 0);
        step();
        drive(1'b1, 32'h208, enc(32'h55AA55AA) ^ ((39'h1 << 8) | (39'h1 << 30)));
        bout.r_valid = 1'b1; bout.r_rdata = 32'h0BAD_F00D; rq.push_back(enc(32'h0BAD_F00D));
        #1;
        chk("t4_r0_valid", bin.r_valid, 1);
        chk("t4_r0_rdata", bin.r_rdata, rq.pop_front());
        chk("t4_r0_gnt", bin.gnt, 0);
        step();
        drive(1'b1, 32'h208, enc(32'h55AA55AA) ^ ((39'h1 << 8) | (39'h1 << 30)));
        bout.r_valid = 1'b1; bout.r_rdata = 32'h1357_9BDF; rq.push_back(enc(32'h1357_9BDF));
        #1;
        chk("t4_r1_rdata", bin.r_rdata, rq.pop_front());
        chk("t4_r1_gnt", bin.gnt, 0);
        step();
        drive(1'b1, 32'h208, enc(32'h55AA55AA) ^ ((39'h1 << 8) | (39'h1 << 30)));
        #1;
        chk("t4_acc_gnt", bin.gnt, 1);
        chk("t4_acc_req", bout.req, 0);
        rq.push_back(zcw);
        step();
        #1;
        chk("t4_loc_valid", bin.r_valid, 1);
        chk("t4_loc_rdata", bin.r_rdata, rq.pop_front());
        chk("t4_uncorr", uncorr_cnt, 2);
        chk("t4_syn", syndrome, syn_of(8) ^ syn_of(30));
        step();
        #1;
        chk("t4_idle_rvalid", bin.r_valid, 0);

        // Fill to MaxOutstanding, fifth request stalls until a response retires
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b0, 32'h300 + 32'(i * 4), enc(32'h0));
            #1;
            chk("t5_fill_gnt", bin.gnt, 1);
        end
        step();
        drive(1'b0, 32'h310, enc(32'h0));
        #1;
        chk("t5_full_gnt", bin.gnt, 0);
        chk("t5_full_req", bout.req, 0);
        step();
        drive(1'b0, 32'h310, enc(32'h0));
        bout.r_valid = 1'b1; bout.r_rdata = 32'h0000_1000; rq.push_back(enc(32'h0000_1000));
        #1;
        chk("t5_ret_gnt", bin.gnt, 0);
        chk("t5_ret_rdata", bin.r_rdata, rq.pop_front());
        step();
        drive(1'b0, 32'h310, enc(32'h0));
        #1;
        chk("t5_fifth_gnt", bin.gnt, 1);
        for (int i = 0; i < 4; i++) resp(32'h2000 + 32'(i));

        // Saturation at CntWidth=2, then clear beats a same-cycle increment
        chk("t6_corr_start", corr_cnt, 1);
        corr_exp = 1;
        for (int i = 0; i < 4; i++) begin
            wr_fwd(32'hA000_0000 + 32'(i), 39'h1 << fb[i], 1'b0);
            corr_exp = (corr_exp == 3) ? 3 : corr_exp + 1;
            chk("t6_corr_sat", corr_cnt, 64'(corr_exp));
            chk("t6_syn", syndrome, syn_of(fb[i]));
        end
        wr_fwd(32'h0000_0077, 39'h1 << 20, 1'b1);
        chk("t6_clr_corr", corr_cnt, 0);
        chk("t6_clr_uncorr", uncorr_cnt, 0);
        chk("t6_clr_err", err, 0);
        chk("t6_clr_syn", syndrome, 0);

        // Reset while a local response is pending
        step();
        drive(1'b1, 32'h400, enc(32'h0000ABCD) ^ ((39'h1 << 2) | (39'h1 << 9)));
        bin.r_gnt = 1'b0;
        #1;
        chk("t7_gnt", bin.gnt, 1);
        rq.push_back(zcw);
        step();
        #1;
        chk("t7_rvalid", bin.r_valid, 1);
        chk("t7_rdata", bin.r_rdata, rq.pop_front());
        chk("t7_uncorr", uncorr_cnt, 1);
        chk("t7_drop", wr_drop, 1);
        rst = 1'b1;
        #1;
        chk("t7_rst_rvalid", bin.r_valid, 0);
        chk("t7_rst_drop", wr_drop, 0);
        chk("t7_rst_uncorr", uncorr_cnt, 0);
        chk("t7_rst_err", err, 0);
        chk("t7_rst_syn", syndrome, 0);
        step();
        rst = 1'b0;
        bin.r_gnt = 1'b1;
        step();
        #1;
        chk("t7_post_rvalid", bin.r_valid, 0);
        chk("sb_rq_empty", 64'(rq.size()), 0);
        chk("sb_wq_empty", 64'(wq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
